// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one external combinational 8-bit ALU, with a registered response slot per requester.
// Build option ALU_ARB_FIXED_PRIO_EN: requester 0 wins every tie and the round-robin pointer is removed.
module alu_arbiter #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  input  logic [2*OP_W-1:0]   req_op,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [2*DATA_W-1:0] rsp_result,
  output logic [1:0]          rsp_zero,
  output logic [DATA_W-1:0]   alu_in1,
  output logic [DATA_W-1:0]   alu_in2,
  output logic [OP_W-1:0]     alu_op,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic                alu_zero
);

  logic [1:0]             vld_p1;
  logic [1:0][DATA_W-1:0] result_p1;
  logic [1:0]             zero_p1;
  logic [1:0]             slot_free;
  logic [1:0]             eligible;
  logic [1:0]             grant;

  // A full slot being drained this cycle can take a new result at the same edge.
  assign slot_free = ~vld_p1 | rsp_ready;
  assign eligible  = req_valid & slot_free;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = 2'b00;
    if (rst_n) begin
      grant[0] = eligible[0];
      grant[1] = eligible[1] & ~eligible[0];
    end
  end
`else
  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (rst_n) begin
      if (&eligible) grant = ptr ? 2'b10 : 2'b01;
      else           grant = eligible;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)        ptr <= 1'b0;
    else if (grant[0]) ptr <= 1'b1;
    else if (grant[1]) ptr <= 1'b0;
  end
`endif

  assign req_ready = grant;

  always_comb begin
    alu_in1 = '0;
    alu_in2 = '0;
    alu_op  = '0;
    for (int i = 0; i < 2; i++) begin
      if (grant[i]) begin
        alu_in1 = req_a[i*DATA_W +: DATA_W];
        alu_in2 = req_b[i*DATA_W +: DATA_W];
        alu_op  = req_op[i*OP_W +: OP_W];
      end
    end
  end

  // Stage p1: ALU result captured into the granted requester's slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1    <= '0;
      result_p1 <= '0;
      zero_p1   <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (grant[i]) begin
          vld_p1[i]    <= 1'b1;
          result_p1[i] <= alu_result;
          zero_p1[i]   <= alu_zero;
        end else if (rsp_ready[i]) begin
          vld_p1[i] <= 1'b0;
        end
      end
    end
  end

  assign rsp_valid  = vld_p1;
  assign rsp_result = result_p1;
  assign rsp_zero   = zero_p1;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares a single combinational 8-bit ALU (2 operands, 3-bit op, result, zero flag) between two independent requesters, e.g. the instruction execute stage (port 0) and the address/DMA helper (port 1).
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block arbitrates round-robin, drives the ALU ports for one cycle per grant and registers the result and zero flag into a per-requester response slot.

Parameters:
- DATA_W, 8, operand/result width; must match the ALU (8).
- OP_W, 3, ALU op code width; must match the ALU (3).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- req_valid  input  2  per-requester request valid (bit i = requester i)
- req_ready  output  2  per-requester request accepted this cycle
- req_a  input  2*DATA_W  operand 1, requester i at [i*DATA_W +: DATA_W]
- req_b  input  2*DATA_W  operand 2, same packing
- req_op  input  2*OP_W  op code, same packing
- rsp_valid  output  2  per-requester response valid
- rsp_ready  input  2  per-requester response consumed
- rsp_result  output  2*DATA_W  registered ALU result per requester
- rsp_zero  output  2  registered ALU zero flag per requester
- alu_in1  output  DATA_W  to ALU input1
- alu_in2  output  DATA_W  to ALU input2
- alu_op  output  OP_W  to ALU op
- alu_result  input  DATA_W  from ALU result
- alu_zero  input  1  from ALU zero

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - rsp_valid=0, rsp_result=0, rsp_zero=0, round-robin pointer=0 (requester 0 preferred next).
  - req_ready is combinational and forced 0 while rst_n=0.
  - Reset mid-operation drops any pending responses and does not replay them.
- Eligibility: requester i is eligible when req_valid[i]=1 and its slot is free. A slot is free when rsp_valid[i]=0, or when rsp_valid[i]=1 and rsp_ready[i]=1 in the same cycle (free-on-drain bypass).
- Arbitration (combinational, one grant per cycle):
  - Only one eligible requester: it is granted.
  - Both eligible: the requester indicated by the pointer is granted.
  - On a grant to requester g, the pointer updates to 1-g at the clk edge. With no grant, the pointer holds.
  - req_ready is one-hot or zero and equals the grant vector.
- ALU drive:
  - With a grant to g, alu_in1/alu_in2/alu_op = req_a/req_b/req_op of g.
  - With no grant, alu_in1=0, alu_in2=0, alu_op=3'b000 (ALU idle op).
  - The block does not interpret op codes; 3'b000 and 3'b111 pass through like any other op.
- Latency: a request accepted at edge N (req_valid & req_ready) captures alu_result and alu_zero into slot g at edge N, so rsp_valid[g]=1 from edge N onward (1-cycle latency). Throughput is 1 op/cycle total.
- Response hold: rsp_result, rsp_zero and rsp_valid stay stable until the edge where rsp_valid & rsp_ready. At that edge rsp_valid clears, unless the same slot is re-granted in that cycle, in which case it stays 1 with new data.
- rsp_ready[i] with rsp_valid[i]=0 is ignored.
- Request-side rule: requesters hold req_a/req_b/req_op stable while req_valid=1 and req_ready=0. The block does not check this rule.
- Simultaneous events: grant to one requester and drain of the other slot in the same cycle are independent and both take effect.
- No state machine beyond the 1-bit pointer and the two slot-valid bits.

Optional Feature:
- Macro ALU_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both are eligible. The pointer is removed and req_ready[1] is granted only when requester 0 is not eligible.
- Undefined: round-robin as described above.
- Latency, response path and ALU drive are identical in both builds.

Test Plan:
- Reset, then requester 0 issues op=001, a=8'h12, b=8'h34 -> req_ready=2'b01 same cycle; next cycle rsp_valid[0]=1, rsp_result[0]=8'h46, rsp_zero[0]=0.
- Both requesters request continuously (r0: op=110, a=b=8'h5A; r1: op=100, a=8'hF0, b=8'h0F) with rsp_ready=2'b11 -> grants alternate 01,10,01,10 starting with 01; r0 results 8'h00 with zero=1; r1 results 8'h00 with zero=1.
- r0 holds rsp_ready[0]=0 after one response while keeping req_valid[0]=1 and r1 idle -> req_ready[0]=0 and rsp_result[0] stable; raising rsp_ready[0] grants r0 in that same cycle (bypass) and rsp_valid[0] stays 1 with new data.
- Assert rst_n=0 for one cycle while rsp_valid=2'b11 -> all rsp_valid=0 and results 0; the next simultaneous request pair is granted to requester 0 first.
- No requests -> alu_op=3'b000, alu_in1=alu_in2=0, req_ready=0, pointer unchanged.
- With ALU_ARB_FIXED_PRIO_EN defined and both requesting continuously with rsp_ready=2'b11 -> req_ready=2'b01 every cycle; requester 1 is granted only after req_valid[0] drops.
